seg7_bus_capture: RTL
=====================

// Module: seg7_bus_capture
// PURPOSE
//  Decoder side of the hex-to-7-segment path. It samples a time-multiplexed, active-low 7-segment bus
//  (segments plus anode selects) and checks that each digit pattern has been stable for a set number of cycles.
//  It then decodes each pattern back to a 4-bit hex value and assembles a full NUM_DIGITS word.
//  Uses: display-path loopback checking on the board and self-checking of display drivers.
// PARAMETERS
//  NUM_DIGITS     4   digits on the bus; word width = 4*NUM_DIGITS
//  STABLE_CYCLES  4   consecutive identical samples required before a digit is accepted (>=2)
//  CNT_W          8   stability counter width; 2**CNT_W > STABLE_CYCLES
// PORTS
//  Clk          in   1             system clock, all logic on rising edge
//  Reset        in   1             synchronous, active-high reset
//  seg_in       in   7             segment pattern, active-low, bit0=a .. bit6=g
//  an_in        in   NUM_DIGITS    digit selects, active-low one-hot; bit k low selects digit k
//  word_out     out  4*NUM_DIGITS  last complete word; digit k in [4k+3:4k]
//  word_valid   out  1             1-cycle pulse when word_out updates
//  err_valid    out  1             1-cycle pulse when a stable, unrecognised pattern is seen
//  err_digit    out  $clog2(NUM_DIGITS)  index of the digit that caused the last err_valid
//  busy         out  1             high while any digit is captured but the word is incomplete
// BEHAVIOUR
//  Reset: word_out=0, word_valid=0, err_valid=0, err_digit=0, busy=0. Staging register, captured
//   flags and counter are cleared; FSM goes to IDLE. Reset mid-scan discards the partial word.
//  Input stage: seg_in and an_in are registered once (seg_q, an_q). A sample counts as "same" when the
//   new inputs equal {an_q, seg_q}. cnt increments on each same sample and saturates at STABLE_CYCLES.
//   Any change sets cnt to 1.
//  Select legality: an_in must be exactly one bit low. All-high or multi-low means no digit is selected.
//   In that case cnt is held at 0 and the FSM goes to IDLE. No error is flagged.
//  FSM:
//   IDLE     -> SETTLE on a legal select.
//   SETTLE   -> ACCEPT when cnt reaches STABLE_CYCLES. Goes to IDLE if the select becomes illegal.
//               Stays in SETTLE, with cnt=1, on any input change.
//   ACCEPT   (1 cycle) decode seg_q:
//              - legal: write the nibble to staging[k], set cap[k].
//              - illegal: pulse err_valid, err_digit=k; cap[k] is unchanged.
//   HOLD     -> wait until the inputs change, so one stable period gives exactly one accept.
//               Then go to SETTLE, or to IDLE if the select is illegal.
//  Decode table (seg -> nibble), the exact inverse of the team encoder:
//   40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9 08->A 03->B 46->C 21->D 06->E 0E->F
//   Any other pattern is illegal.
//  Word completion: on the ACCEPT edge that makes cap all ones (counting the digit being written),
//   word_out <= staging with the new nibble, word_valid=1 for the next cycle, cap cleared.
//  Re-capture of an already captured digit before the word completes overwrites its nibble.
//   It does not complete the word.
//  busy = |cap. word_out holds its value between completions.
//  Latency: a digit first presented at edge t, then held, is accepted at edge t+STABLE_CYCLES+1.
//   word_valid is high in the cycle after the completing accept.
// CONFIGURATION
//  SEG7_CAPTURE_BLANK_EN defined: pattern 7F (all segments off) is legal and decodes as nibble 0.
//   Its digit is treated as captured, and the output blank_mask (NUM_DIGITS) is added.
//   blank_mask updates together with word_out and has bit k set if digit k was blank.
//  Not defined: 7F is illegal and raises err_valid like any unknown pattern. The blank_mask port is absent.
// TESTING
//  1 Reset, then hold an=1110 seg=40 for 6 cycles -> one accept, cap=0001, busy=1, no word_valid.
//  2 Scan digits 0..3 with seg 30,12,08,0E, 6 cycles each -> word_out=16'hFA53, single word_valid pulse.
//  3 Digit 1 shows 7F, stable -> err_valid with err_digit=1 (SEG7_CAPTURE_BLANK_EN off).
//    With the macro on -> nibble 0 is accepted.
//  4 Glitch: seg changes every 3 cycles with STABLE_CYCLES=4 -> no accept, no word_valid.
//  5 an=1100 (two low) held 10 cycles -> FSM stays in IDLE, no err_valid, cap unchanged.
//  6 Reset asserted after 2 of 4 digits are captured, then a full scan -> word_out reflects only post-reset digits.

Source files
------------

// File: rtl/seg7_bus_capture.sv
// Samples a time-multiplexed active-low 7-segment bus, waits for each digit to be stable,
// decodes it back to hex and assembles a NUM_DIGITS word. Optional: SEG7_CAPTURE_BLANK_EN.
module seg7_bus_capture #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  localparam int unsigned IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] word_out,
  output logic                    word_valid,
  output logic                    err_valid,
  output logic [IDX_W-1:0]        err_digit,
  output logic                    busy
`ifdef SEG7_CAPTURE_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]   blank_mask
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StAccept, StHold} state_e;

  state_e                  state_q, state_d;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
  logic [4*NUM_DIGITS-1:0] word_q, word_d;
  logic [NUM_DIGITS-1:0]   cap_q, cap_d;
  logic                    word_valid_q, word_valid_d;
  logic                    err_valid_q, err_valid_d;
  logic [IDX_W-1:0]        err_digit_q, err_digit_d;
  logic [IDX_W-1:0]        sel_idx;
  logic                    same, legal_in;
  logic                    dec_legal, dec_blank;
  logic [3:0]              dec_nib;
`ifdef SEG7_CAPTURE_BLANK_EN
  logic [NUM_DIGITS-1:0]   blank_stage_q, blank_stage_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
`endif

  function automatic logic exactly_one_low(input logic [NUM_DIGITS-1:0] an);
    int unsigned lows;
    lows = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) lows++;
    end
    return lows == 1;
  endfunction

  assign same     = (an_in == an_q) && (seg_in == seg_q);
  assign legal_in = exactly_one_low(an_in);

  // Only meaningful while an_q is a legal one-low select.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) sel_idx = IDX_W'(i);
    end
  end

  // Inverse of the team encoder.
  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (seg_q)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
`ifdef SEG7_CAPTURE_BLANK_EN
      7'h7F: dec_blank = 1'b1;
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    if (!legal_in) begin
      cnt_d = '0;
    end else if (!same) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    staging_d    = staging_q;
    cap_d        = cap_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    err_valid_d  = 1'b0;
    err_digit_d  = err_digit_q;
`ifdef SEG7_CAPTURE_BLANK_EN
    blank_stage_d = blank_stage_q;
    blank_d       = blank_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (legal_in) state_d = StSettle;
      end
      StSettle: begin
        if (!legal_in) state_d = StIdle;
        else if (same && (cnt_q == CNT_W'(STABLE_CYCLES))) state_d = StAccept;
      end
      StAccept: begin
        if (dec_legal) begin
          staging_d[4*sel_idx +: 4] = dec_nib;
          cap_d[sel_idx]            = 1'b1;
`ifdef SEG7_CAPTURE_BLANK_EN
          blank_stage_d[sel_idx]    = dec_blank;
`endif
          if (&cap_d) begin
            word_d       = staging_d;
            word_valid_d = 1'b1;
            cap_d        = '0;
`ifdef SEG7_CAPTURE_BLANK_EN
            blank_d      = blank_stage_d;
`endif
          end
        end else begin
          err_valid_d = 1'b1;
          err_digit_d = sel_idx;
        end
        if (!legal_in) state_d = StIdle;
        else if (same) state_d = StHold;
        else state_d = StSettle;
      end
      StHold: begin
        if (!legal_in) state_d = StIdle;
        else if (!same) state_d = StSettle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StIdle;
      seg_q        <= '1;
      an_q         <= '1;
      cnt_q        <= '0;
      staging_q    <= '0;
      cap_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      err_valid_q  <= 1'b0;
      err_digit_q  <= '0;
`ifdef SEG7_CAPTURE_BLANK_EN
      blank_stage_q <= '0;
      blank_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_in;
      an_q         <= an_in;
      cnt_q        <= cnt_d;
      staging_q    <= staging_d;
      cap_q        <= cap_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      err_valid_q  <= err_valid_d;
      err_digit_q  <= err_digit_d;
`ifdef SEG7_CAPTURE_BLANK_EN
      blank_stage_q <= blank_stage_d;
      blank_q       <= blank_d;
`endif
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign err_valid  = err_valid_q;
  assign err_digit  = err_digit_q;
  assign busy       = |cap_q;
`ifdef SEG7_CAPTURE_BLANK_EN
  assign blank_mask = blank_q;
`endif

endmodule
